// File: rtl/apx_err_monitor_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor.
// Holds the FSM state enum, datapath widths and the supported latency range.
package apx_err_monitor_pkg;

  localparam int unsigned OP_W        = 8;   // operand width
  localparam int unsigned PROD_W      = 16;  // product / error-distance width
  localparam int unsigned SUM_W       = 32;  // error-distance sum width
  localparam int unsigned CNT_W       = 17;  // error count width (up to 65536)
  localparam int unsigned IDX_W       = 2 * OP_W;
  localparam int unsigned MAX_MUL_LAT = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain
  } state_e;

endpackage

// File: rtl/apx_err_delay.sv
// Operand/valid delay line matching the latency of the multiplier under test.
// Depth = 0 is a pure wire bypass; otherwise Depth register stages.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           clears every valid bit in flight (and the incoming one)
//   valid_i/a_i/b_i   issued operand pair and its valid bit
//   valid_o/a_o/b_o   the same pair, Depth cycles later
module apx_err_delay
  import apx_err_monitor_pkg::*;
#(
  parameter int unsigned Depth = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  output logic            valid_o,
  output logic [OP_W-1:0] a_o,
  output logic [OP_W-1:0] b_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst_n, flush_i};
    assign valid_o = valid_i;
    assign a_o     = a_i;
    assign b_o     = b_i;
  end else begin : g_pipe
    logic [Depth-1:0] valid_q;
    logic [OP_W-1:0]  a_q [Depth];
    logic [OP_W-1:0]  b_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= '0;
        for (int i = 0; i < int'(Depth); i++) begin
          a_q[i] <= '0;
          b_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= valid_i & ~flush_i;
        a_q[0]     <= a_i;
        b_q[0]     <= b_i;
        for (int i = 1; i < int'(Depth); i++) begin
          valid_q[i] <= valid_q[i-1] & ~flush_i;
          a_q[i]     <= a_q[i-1];
          b_q[i]     <= b_q[i-1];
        end
      end
    end

    assign valid_o = valid_q[Depth-1];
    assign a_o     = a_q[Depth-1];
    assign b_o     = b_q[Depth-1];
  end

endmodule

// File: rtl/apx_err_monitor.sv
// Exhaustive error monitor for an external 8x8 approximate multiplier.
// Sweeps all 65536 operand pairs, compares each returned product with the
// exact one and accumulates error count, error-distance sum and the first
// pair reaching the maximum error distance.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, abort               sweep control
//   a_out, b_out               operands to the multiplier under test
//   prod_apx                   its product, MUL_LAT cycles after a_out/b_out
//   busy, done, res_valid      status
//   err_cnt, sum_ed, max_ed    statistics
//   max_a, max_b               first pair that reached max_ed
// MUL_LAT legal range is 0..MAX_MUL_LAT.
module apx_err_monitor
  import apx_err_monitor_pkg::*;
#(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [OP_W-1:0]   a_out,
  output logic [OP_W-1:0]   b_out,
  input  logic [PROD_W-1:0] prod_apx,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [PROD_W-1:0] max_ed,
  output logic [OP_W-1:0]   max_a,
  output logic [OP_W-1:0]   max_b
);

  // Drain covers the delay line plus stages E and A.
  localparam logic [2:0] DrainLast = 3'(MUL_LAT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         drain_q, drain_d;
  logic               res_valid_q, res_valid_d;
  logic               clr_stats;
  logic               flush;
  logic               issue_valid;

  logic               d_valid;
  logic [OP_W-1:0]    d_a, d_b;
  logic [PROD_W-1:0]  exact, ed;

  logic               e_valid_q;
  logic [PROD_W-1:0]  e_ed_q;
  logic [OP_W-1:0]    e_a_q, e_b_q;

  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0]   sum_ed_q, sum_ed_d;
  logic [PROD_W-1:0]  max_ed_q, max_ed_d;
  logic [OP_W-1:0]    max_a_q, max_a_d, max_b_q, max_b_d;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    clr_stats   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StSweep;
          idx_d       = '0;
          clr_stats   = 1'b1;
          res_valid_d = 1'b0;
        end
      end
      StSweep: begin
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == '1) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
        end else if (drain_q == DrainLast) begin
          state_d     = StIdle;
          done        = 1'b1;
          res_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign flush       = abort & busy;
  assign issue_valid = (state_q == StSweep);
  assign a_out       = idx_q[IDX_W-1:OP_W];
  assign b_out       = idx_q[OP_W-1:0];
  // Results become visible in the done cycle itself.
  assign res_valid   = res_valid_q | done;

  // ---------------------------------------------------------------- delay line
  apx_err_delay #(
    .Depth(MUL_LAT)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .valid_i(issue_valid),
    .a_i    (a_out),
    .b_i    (b_out),
    .valid_o(d_valid),
    .a_o    (d_a),
    .b_o    (d_b)
  );

  // ---------------------------------------------------------------- stage E
  always_comb begin
    exact = PROD_W'(d_a) * PROD_W'(d_b);
    ed    = (exact >= prod_apx) ? (exact - prod_apx) : (prod_apx - exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid_q <= 1'b0;
      e_ed_q    <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
    end else begin
      e_valid_q <= d_valid & ~flush;
      e_ed_q    <= ed;
      e_a_q     <= d_a;
      e_b_q     <= d_b;
    end
  end

  // ---------------------------------------------------------------- stage A
  always_comb begin
    err_cnt_d = err_cnt_q;
    sum_ed_d  = sum_ed_q;
    max_ed_d  = max_ed_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    if (clr_stats) begin
      err_cnt_d = '0;
      sum_ed_d  = '0;
      max_ed_d  = '0;
      max_a_d   = '0;
      max_b_d   = '0;
    end else if (e_valid_q && !flush) begin
      err_cnt_d = err_cnt_q + CNT_W'(e_ed_q != '0);
      sum_ed_d  = sum_ed_q + SUM_W'(e_ed_q);
      // Strict compare: ties keep the earlier pair.
      if (e_ed_q > max_ed_q) begin
        max_ed_d = e_ed_q;
        max_a_d  = e_a_q;
        max_b_d  = e_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      sum_ed_q  <= sum_ed_d;
      max_ed_q  <= max_ed_d;
      max_a_q   <= max_a_d;
      max_b_q   <= max_b_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign sum_ed  = sum_ed_q;
  assign max_ed  = max_ed_q;
  assign max_a   = max_a_q;
  assign max_b   = max_b_q;

endmodule

// File: tb/tb_apx_err_monitor.sv
// Bench for apx_err_monitor: five instances share clk/rst_n/start/abort, each
// with a different multiplier model:
//   0: exact, MUL_LAT=0          1: bit0 cleared, MUL_LAT=0
//   2: tied to zero, MUL_LAT=0   3: exact, two register stages, MUL_LAT=2
//   4: exact unregistered, MUL_LAT=2 (misaligned)
module tb_apx_err_monitor;

  localparam int NDUT = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [7:0]  a_w     [NDUT];
  logic [7:0]  b_w     [NDUT];
  logic [15:0] prod_w  [NDUT];
  logic        busy_w  [NDUT];
  logic        done_w  [NDUT];
  logic        rv_w    [NDUT];
  logic [16:0] err_w   [NDUT];
  logic [31:0] sum_w   [NDUT];
  logic [15:0] max_w   [NDUT];
  logic [7:0]  ma_w    [NDUT];
  logic [7:0]  mb_w    [NDUT];

  logic [15:0] p3_s1 = '0;
  logic [15:0] p3_s2 = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L = (g >= 3) ? 2 : 0;
    apx_err_monitor #(
      .MUL_LAT(L)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .a_out    (a_w[g]),
      .b_out    (b_w[g]),
      .prod_apx (prod_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .res_valid(rv_w[g]),
      .err_cnt  (err_w[g]),
      .sum_ed   (sum_w[g]),
      .max_ed   (max_w[g]),
      .max_a    (ma_w[g]),
      .max_b    (mb_w[g])
    );
  end

  // Multipliers under test
  assign prod_w[0] = 16'(a_w[0]) * 16'(b_w[0]);
  assign prod_w[1] = (16'(a_w[1]) * 16'(b_w[1])) & 16'hFFFE;
  assign prod_w[2] = 16'd0;
  assign prod_w[3] = p3_s2;
  assign prod_w[4] = 16'(a_w[4]) * 16'(b_w[4]);

  always @(posedge clk) begin
    p3_s1 <= 16'(a_w[3]) * 16'(b_w[3]);
    p3_s2 <= p3_s1;
  end

  // ------------------------------------------------------------ scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct {
    int unsigned err;
    int unsigned sum;
    int unsigned mx;
    int unsigned ma;
    int unsigned mb;
  } st_t;

  st_t exp_st [NDUT];

  // Statistics over the sweep, from the behaviour of each model as seen by the
  // monitor. Kind 4 compares pair k against the product of the pair on the
  // operand bus two cycles later (pair k+2, held at 65535 once the sweep ends).
  function automatic st_t model(input int kind);
    st_t s;
    s = '{default: 0};
    for (int k = 0; k < 65536; k++) begin
      int unsigned a, b, ex, ap, ed, k2;
      a  = k / 256;
      b  = k % 256;
      ex = a * b;
      case (kind)
        1:       ap = ex - (ex % 2);
        2:       ap = 0;
        4: begin
          k2 = (k + 2 > 65535) ? 65535 : k + 2;
          ap = (k2 / 256) * (k2 % 256);
        end
        default: ap = ex;
      endcase
      ed = (ex >= ap) ? ex - ap : ap - ex;
      if (ed != 0) s.err++;
      s.sum += ed;
      if (ed > s.mx) begin
        s.mx = ed;
        s.ma = a;
        s.mb = b;
      end
    end
    return s;
  endfunction

  // ------------------------------------------------------------ per-cycle checker
  // n counts cycles since the accepted start: n=1 is the first SWEEP cycle.
  logic chk_on = 1'b0;
  int   n = -1;

  always @(posedge clk) begin
    if (chk_on && start && n < 0) n <= 1;
    else if (n >= 0) n <= n + 1;
  end

  always @(negedge clk) begin
    if (chk_on && n >= 1 && n <= 65546) begin
      for (int g = 0; g < NDUT; g += 3) begin
        int last, idx;
        last = (g >= 3) ? 65540 : 65538;
        idx  = (n - 1 > 65535) ? 65535 : n - 1;
        chk($sformatf("busy%0d n=%0d", g, n), 32'(busy_w[g]), 32'(n <= last));
        chk($sformatf("done%0d n=%0d", g, n), 32'(done_w[g]), 32'(n == last));
        chk($sformatf("res_valid%0d n=%0d", g, n), 32'(rv_w[g]), 32'(n >= last));
        chk($sformatf("ab%0d n=%0d", g, n), 32'({a_w[g], b_w[g]}), 32'(idx));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("%s busy%0d", tag, g), 32'(busy_w[g]), 0);
      chk($sformatf("%s done%0d", tag, g), 32'(done_w[g]), 0);
      chk($sformatf("%s res_valid%0d", tag, g), 32'(rv_w[g]), 0);
      chk($sformatf("%s ab%0d", tag, g), 32'({a_w[g], b_w[g]}), 0);
      chk($sformatf("%s err%0d", tag, g), 32'(err_w[g]), 0);
      chk($sformatf("%s sum%0d", tag, g), sum_w[g], 0);
      chk($sformatf("%s max%0d", tag, g), 32'({max_w[g], ma_w[g], mb_w[g]}), 0);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    bit hit;
    for (int k = 0; k < NDUT; k++) exp_st[k] = model(k);

    // Reset state
    #2;
    chk_all_zero("reset");

    // start + abort together in IDLE: the sweep starts
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start+abort busy", 32'(busy_w[0]), 1);

    // Abort at idx=1000
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if ({a_w[0], b_w[0]} == 16'd1000) hit = 1'b1;
    end
    chk("reach idx 1000", 32'(hit), 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk($sformatf("abort busy%0d", g), 32'(busy_w[g]), 0);
    for (int c = 0; c < 8; c++) begin
      for (int g = 0; g < NDUT; g++) begin
        chk($sformatf("abort done%0d", g), 32'(done_w[g]), 0);
        chk($sformatf("abort res_valid%0d", g), 32'(rv_w[g]), 0);
      end
      @(negedge clk);
    end

    // Reset pulse mid-sweep
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (600) @(posedge clk);
    #2;
    chk("pre-reset err2 nonzero", 32'(err_w[2] != 0), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-sweep reset");

    // Release and start on the very next edge; full sweep under the checker
    @(negedge clk);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // start while busy must be ignored
    repeat (30000) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    repeat (35600) @(posedge clk);
    @(negedge clk);

    // Final statistics against the model
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("err%0d", g), 32'(err_w[g]), exp_st[g].err);
      chk($sformatf("sum%0d", g), sum_w[g], exp_st[g].sum);
      chk($sformatf("max_ed%0d", g), 32'(max_w[g]), exp_st[g].mx);
      chk($sformatf("max_a%0d", g), 32'(ma_w[g]), exp_st[g].ma);
      chk($sformatf("max_b%0d", g), 32'(mb_w[g]), exp_st[g].mb);
      chk($sformatf("final res_valid%0d", g), 32'(rv_w[g]), 1);
    end

    // Hand-computed literals
    chk("lit err0", 32'(err_w[0]), 0);
    chk("lit sum0", sum_w[0], 0);
    chk("lit err1", 32'(err_w[1]), 16384);
    chk("lit sum1", sum_w[1], 16384);
    chk("lit max1", 32'({max_w[1], ma_w[1], mb_w[1]}), {16'd1, 8'd1, 8'd1});
    chk("lit err2", 32'(err_w[2]), 65025);
    chk("lit sum2", sum_w[2], 32'd1065369600);
    chk("lit max2", 32'({max_w[2], ma_w[2], mb_w[2]}), {16'd65025, 8'd255, 8'd255});
    chk("lit err3", 32'(err_w[3]), 0);
    chk("lit max3", 32'(max_w[3]), 0);
    chk("err4 nonzero", 32'(err_w[4] != 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apx_err_monitor.md
APX_ERR_MONITOR -- requirements
Module: apx_err_monitor

Interface
REQ-001 Parameter MUL_LAT, default 0, legal 0..3: cycles between a_out/b_out changing and the matching prod_apx arriving from the multiplier under test.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin exhaustive sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep; sampled in SWEEP and DRAIN.
REQ-006 a_out  output  8  operand A driven to the 8x8 multiplier under test.
REQ-007 b_out  output  8  operand B driven to the 8x8 multiplier under test.
REQ-008 prod_apx  input  16  approximate product returned by the multiplier under test.
REQ-009 busy  output  1  high in SWEEP and DRAIN.
REQ-010 done  output  1  one-cycle pulse when all statistics are final.
REQ-011 res_valid  output  1  high from done until the next accepted start, abort or reset.
REQ-012 err_cnt  output  17  count of pairs with prod_apx != a*b.
REQ-013 sum_ed  output  32  sum of |a*b - prod_apx| over all pairs.
REQ-014 max_ed  output  16  largest single error distance.
REQ-015 max_a, max_b  output  8 each  first operand pair, in sweep order, that reached max_ed.

Function
REQ-016 FSM states IDLE, SWEEP, DRAIN; IDLE->SWEEP on start; SWEEP->DRAIN after issuing pair 65535; DRAIN->IDLE after MUL_LAT+2 cycles, asserting done in that final cycle.
REQ-017 On accepting start, err_cnt, sum_ed, max_ed, max_a, max_b SHALL clear to 0 and res_valid SHALL drop.
REQ-018 16-bit issue counter idx; a_out=idx[15:8], b_out=idx[7:0]; idx=0 in the first SWEEP cycle, +1 per cycle, no stall, no wrap.
REQ-019 a_out/b_out SHALL be registered outputs and SHALL hold their last value outside SWEEP.
REQ-020 The issued operand pair and a valid bit SHALL pass through a MUL_LAT-deep delay line; when MUL_LAT=0 the delay line is bypassed.
REQ-021 Stage E registers the 16-bit exact product of the delayed operands, the error distance ed=|exact-prod_apx|, and the pair itself.
REQ-022 Stage A accumulates a valid stage-E entry: err_cnt+=(ed!=0); sum_ed+=ed; strictly ed>max_ed updates max_ed, max_a, max_b, so ties keep the earlier pair.
REQ-023 sum_ed SHALL NOT overflow: the worst case, 65536*65025, is below 2^32.
REQ-024 done SHALL occur exactly 65538+MUL_LAT cycles after the cycle in which start was sampled.
REQ-025 start while busy SHALL be ignored; start and abort in the same IDLE cycle SHALL start the sweep.
REQ-026 abort in SWEEP/DRAIN SHALL return to IDLE next cycle, flush the valid pipeline, suppress done and keep res_valid low; partial statistics are held.

Reset
REQ-027 While rst_n=0: state IDLE, idx=0, a_out=b_out=0, all valid bits 0, busy=done=res_valid=0, and all statistics 0.
REQ-028 Reset deassertion SHALL require no extra settling cycles; the first start is accepted on the first clk edge after deassertion.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the widths OP_W=8, PROD_W=16, SUM_W=32, CNT_W=17, and the maximum MUL_LAT.
REQ-030 One sub-module, apx_err_delay, SHALL implement the parameterised operand/valid delay line; the multiplier under test stays outside this block.

Verification
REQ-031 Exact model (prod_apx=a_out*b_out), MUL_LAT=0 -> err_cnt=0, sum_ed=0, max_ed=0, max_a=max_b=0, done at cycle start+65538.
REQ-032 Model returns a*b with bit0 cleared -> err_cnt=16384, sum_ed=16384, max_ed=1, max_a=1, max_b=1.
REQ-033 prod_apx tied to 0 -> err_cnt=65025, sum_ed=1065369600, max_ed=65025, max_a=max_b=255.
REQ-034 MUL_LAT=2 with a two-stage-registered exact model -> all statistics 0, done at cycle start+65540; MUL_LAT=2 with an unregistered model -> err_cnt nonzero.
REQ-035 abort at idx=1000 -> busy low next cycle, no done, res_valid=0; a subsequent start yields results identical to REQ-031.
REQ-036 rst_n pulsed low mid-SWEEP -> all outputs 0 immediately; start after release completes a normal sweep.
